alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_pkg.sv | 37 +++
 rtl/mdu_core.sv | 123 ++++++++++++
 rtl/alu_mdu.sv | 133 +++++++++++++
 tb/tb_alu_mdu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : ALU control codes, multiply/divide op codes and MDU state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [2:0] MD_NONE2 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_core.sv
// ============================================================================
// Module : mdu_core
// Brief  : Iterative shift-add multiplier / restoring divider with sign fixup.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] r_mag_b;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;

  logic             w_signed;
  logic             w_is_div;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_is_div = (i_op == MD_DIV)  || (i_op == MD_DIVU);
  assign w_mag_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // Multiply: multiplier sits in r_p_lo and shifts out LSB-first while the
  // partial product accumulates in r_p_hi.
  assign w_addend = r_p_lo[0] ? {1'b0, r_mag_b} : '0;
  assign w_sum    = {1'b0, r_p_hi} + w_addend;

  // Divide: r_p_hi is the partial remainder, r_p_lo shifts dividend out / quotient in.
  assign w_shift  = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_mag_b};
  assign w_borrow = w_diff[WIDTH];

  assign o_last = (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a_orig  <= '0;
      r_mag_b   <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
    end else if (i_load) begin
      r_cnt     <= '0;
      r_is_div  <= w_is_div;
      r_neg_res <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_rem <= w_signed & i_a[WIDTH-1];
      r_b_zero  <= (i_b == '0);
      r_a_orig  <= i_a;
      r_mag_b   <= w_mag_b;
      r_p_hi    <= '0;
      r_p_lo    <= w_mag_a;
    end else if (i_step) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      if (r_is_div) begin
        r_p_hi <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_p_lo <= {r_p_lo[WIDTH-2:0], ~w_borrow};
      end else begin
        r_p_hi <= w_sum[WIDTH:1];
        r_p_lo <= {w_sum[0], r_p_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod     = {r_p_hi, r_p_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo      = r_neg_res ? -r_p_lo : r_p_lo;
  assign w_rem      = r_neg_rem ? -r_p_hi : r_p_hi;

  always_comb begin
    o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    o_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        o_hi = r_a_orig;
        o_lo = '1;
      end else begin
        o_hi = w_rem;
        o_lo = w_quo;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
// Module : alu_mdu
// Brief  : Combinational ALU plus iterative multiply/divide unit with HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluout,
  output logic             overflow,
  output logic             zero,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_ov_add;
  logic             w_ov_sub;
  logic             w_slt;

  assign w_sum    = srca + srcb;
  assign w_diff   = srca - srcb;
  assign w_ov_add = (srca[WIDTH-1] == srcb[WIDTH-1]) && (w_sum[WIDTH-1]  != srca[WIDTH-1]);
  assign w_ov_sub = (srca[WIDTH-1] != srcb[WIDTH-1]) && (w_diff[WIDTH-1] != srca[WIDTH-1]);
  // The sign of the difference is wrong exactly when the subtraction overflows.
  assign w_slt    = w_diff[WIDTH-1] ^ w_ov_sub;

  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    case (alucontrol)
      ALU_AND:  aluout = srca & srcb;
      ALU_OR:   aluout = srca | srcb;
      ALU_ADD:  begin aluout = w_sum;  overflow = w_ov_add; end
      ALU_ANDN: aluout = srca & ~srcb;
      ALU_ORN:  aluout = srca | ~srcb;
      ALU_SUB:  begin aluout = w_diff; overflow = w_ov_sub; end
      ALU_SLT:  aluout = {{(WIDTH-1){1'b0}}, w_slt};
      default:  aluout = '0;
    endcase
  end

  assign zero = (aluout == '0);

  mdu_state_t       r_state;
  mdu_state_t       w_state_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_move_hi;
  logic             w_move_lo;
  logic             w_last;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;

  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept  = w_ready && md_start &&
                     ((md_op == MD_MULT) || (md_op == MD_MULTU) ||
                      (md_op == MD_DIV)  || (md_op == MD_DIVU));
  assign w_move_hi = w_ready && md_start && (md_op == MD_MTHI);
  assign w_move_lo = w_ready && md_start && (md_op == MD_MTLO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN: begin
        md_busy = 1'b1;
        if (w_last) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        md_busy     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        md_done     = 1'b1;
        w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_op   (md_op),
    .i_a    (srca),
    .i_b    (srcb),
    .i_step (r_state == ST_RUN),
    .o_last (w_last),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (r_state == ST_FIX) begin
      hi <= w_core_hi;
      lo <= w_core_lo;
    end else begin
      if (w_move_hi) hi <= srca;
      if (w_move_lo) lo <= srca;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module : tb_alu_mdu
// Brief  : Directed self-checking bench for alu_mdu (WIDTH 32 and WIDTH 8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] srca = '0, srcb = '0;
  logic [2:0]  alucontrol = '0, md_op = '0;
  logic        md_start = 1'b0;
  logic [31:0] aluout, hi, lo;
  logic        overflow, zero, md_busy, md_done;

  logic [7:0]  srca8 = '0, srcb8 = '0;
  logic [2:0]  alucontrol8 = '0, md_op8 = '0;
  logic        md_start8 = 1'b0;
  logic [7:0]  aluout8, hi8, lo8;
  logic        overflow8, zero8, md_busy8, md_done8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
    .aluout(aluout), .overflow(overflow), .zero(zero), .md_op(md_op),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .srca(srca8), .srcb(srcb8), .alucontrol(alucontrol8),
    .aluout(aluout8), .overflow(overflow8), .zero(zero8), .md_op(md_op8),
    .md_start(md_start8), .md_busy(md_busy8), .md_done(md_done8), .hi(hi8), .lo(lo8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start an op at edge 0, scramble operands afterwards, check timing and result.
  task automatic md_run(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    md_op = op; srca = a; srcb = b; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MD_NONE; srca = 32'hDEAD_BEEF; srcb = 32'h0000_1234;
    check_eq({tag, " busy@1"}, md_busy, 1);
    repeat (32) @(posedge clk);
    #1;
    check_eq({tag, " done@33"}, md_done, 0);
    @(posedge clk); #1;
    check_eq({tag, " done@34"}, md_done, 1);
    check_eq({tag, " busy@34"}, md_busy, 0);
    check_eq({tag, " hi"}, hi, exp_hi);
    check_eq({tag, " lo"}, lo, exp_lo);
    @(posedge clk); #1;
    check_eq({tag, " done@35"}, md_done, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, y;
    logic        ov, z;
  } alu_vec_t;

  alu_vec_t alu_tbl[10] = '{
    '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0},
    '{ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0},
    '{ALU_SUB,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0},
    '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1},
    '{ALU_AND,  32'hF0F0_FFFF, 32'h0F0F_00FF, 32'h0000_00FF, 1'b0, 1'b0},
    '{ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0},
    '{ALU_ANDN, 32'hF0F0_FFFF, 32'h0F0F_00FF, 32'hF0F0_FF00, 1'b0, 1'b0},
    '{ALU_ORN,  32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0},
    '{ALU_ZERO, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1},
    '{ALU_SLT,  32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 1'b1}
  };

  initial begin
    int n_done;

    #2;
    check_eq("rst hi", hi, 0);
    check_eq("rst lo", lo, 0);
    check_eq("rst busy", md_busy, 0);
    check_eq("rst done", md_done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational ALU, no clock needed.
    foreach (alu_tbl[i]) begin
      alucontrol = alu_tbl[i].op; srca = alu_tbl[i].a; srcb = alu_tbl[i].b;
      #1;
      check_eq($sformatf("alu%0d y", i), aluout, alu_tbl[i].y);
      check_eq($sformatf("alu%0d ov", i), overflow, alu_tbl[i].ov);
      check_eq($sformatf("alu%0d z", i), zero, alu_tbl[i].z);
    end

    md_run("mult",  MD_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
    md_run("div",   MD_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu0", MD_DIVU,  32'h7,         32'h0, 32'h0000_0007, 32'hFFFF_FFFF);
    md_run("divmn", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    md_run("div0s", MD_DIV,   32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    md_run("divu",  MD_DIVU,  32'd100,       32'd7, 32'd2, 32'd14);
    md_run("multn", MD_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);

    // mthi / mtlo write at the start edge, no busy or done.
    @(negedge clk);
    md_op = MD_MTHI; srca = 32'h1234_5678; md_start = 1'b1;
    @(posedge clk); #1;
    check_eq("mthi hi", hi, 32'h1234_5678);
    check_eq("mthi busy", md_busy, 0);
    md_op = MD_MTLO; srca = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check_eq("mtlo lo", lo, 32'hCAFE_F00D);
    check_eq("mtlo hi", hi, 32'h1234_5678);
    check_eq("mtlo done", md_done, 0);
    md_op = MD_NONE2;
    @(posedge clk); #1;
    check_eq("none busy", md_busy, 0);
    md_start = 1'b0;

    // Second start in cycle 5 while busy must be ignored.
    @(negedge clk);
    md_op = MD_DIV; srca = 32'hFFFF_FFF9; srcb = 32'h2; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    md_op = MD_MULTU; srca = 32'd3; srcb = 32'd5; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    check_eq("ign done", md_done, 1);
    check_eq("ign hi", hi, 32'hFFFF_FFFF);
    check_eq("ign lo", lo, 32'hFFFF_FFFD);

    // Abort by asynchronous reset in cycle 10.
    @(negedge clk);
    md_op = MD_DIV; srca = 32'd100; srcb = 32'd7; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort busy", md_busy, 0);
    check_eq("abort hi", hi, 0);
    check_eq("abort lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_done) n_done++;
    end
    check_eq("abort no done", n_done, 0);
    check_eq("abort hi kept", hi, 0);

    // First start after reset release is accepted immediately.
    md_run("postrst", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    // WIDTH=8 instance.
    @(negedge clk);
    md_op8 = MD_MULT; srca8 = 8'h80; srcb8 = 8'h80; md_start8 = 1'b1;
    @(posedge clk); #1;
    md_start8 = 1'b0; srca8 = 8'h11; srcb8 = 8'h22;
    repeat (8) @(posedge clk);
    #1;
    check_eq("w8 done@9", md_done8, 0);
    @(posedge clk); #1;
    check_eq("w8 done@10", md_done8, 1);
    check_eq("w8 hi", hi8, 8'h40);
    check_eq("w8 lo", lo8, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
